// File: rtl/muldiv_hilo_unit.sv
// Multicycle multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_MUL  | shift-add multiply, one bit per cycle
  // S_DIV  | restoring divide, one quotient bit per cycle
  // S_FIX  | apply result signs, write hi/lo
  // S_DONE | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_abs_rs;
  logic [WIDTH-1:0]   w_abs_rt;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~op[0];
  assign w_rs_neg = w_signed & rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & rt_data[WIDTH-1];
  assign w_abs_rs = w_rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign w_abs_rt = w_rt_neg ? (~rt_data + 1'b1) : rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

  // Divide: acc = {remainder, dividend bits not yet consumed}, shifted left each step.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_diff[WIDTH];

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                if (op[1] && (rt_data == '0)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_dz    <= 1'b1;
                end else begin
                  r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_abs_rs} : {{WIDTH{1'b0}}, w_abs_rt};
                  r_opb    <= op[1] ? w_abs_rt : w_abs_rs;
                  r_neg_q  <= w_rs_neg ^ w_rt_neg;
                  r_neg_r  <= w_rs_neg;
                  r_is_div <= op[1];
                  r_cnt    <= CW'(WIDTH);
                  r_busy   <= 1'b1;
                  r_state  <= op[1] ? S_DIV : S_MUL;
                end
              end
              3'b100: begin
                r_hi    <= rs_data;
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              3'b101: begin
                r_lo    <= rs_data;
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_div_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed vectors at WIDTH=32 and WIDTH=8.
module tb_muldiv_hilo_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0;
  logic [2:0]  op32 = 3'b0;
  logic [31:0] rs32 = '0, rt32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'b0;
  logic [7:0]  rs8 = '0, rt8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  muldiv_hilo_unit #(.WIDTH(32)) u32 (
    .clock(clock), .reset(rst_n), .start(start32), .op(op32),
    .rs_data(rs32), .rt_data(rt32), .busy(busy32), .done(done32),
    .div_by_zero(dz32), .hi(hi32), .lo(lo32));

  muldiv_hilo_unit #(.WIDTH(8)) u8 (
    .clock(clock), .reset(rst_n), .start(start8), .op(op8),
    .rs_data(rs8), .rt_data(rt8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .hi(hi8), .lo(lo8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon32();
    exp_t e;
    forever begin
      @(negedge clock);
      if (dz32 && !done32) chk("dz32_without_done", 32'(dz32), 32'd0);
      if (done32) begin
        if (q32.size() == 0) begin
          chk("unexpected_done32", 32'(done32), 32'd0);
        end else begin
          e = q32.pop_front();
          chk("hi32", hi32, e.hi);
          chk("lo32", lo32, e.lo);
          chk("dz32", 32'(dz32), 32'(e.dz));
          chk("busy32_at_done", 32'(busy32), 32'd0);
        end
      end
    end
  endtask

  task automatic mon8();
    exp_t e;
    forever begin
      @(negedge clock);
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          chk("hi8", 32'(hi8), e.hi);
          chk("lo8", 32'(lo8), e.lo);
          chk("dz8", 32'(dz8), 32'(e.dz));
        end
      end
    end
  endtask

  // exp_edges: rising edges after the start edge until done is visible.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int exp_edges, input logic noise);
    exp_t e;
    logic got;
    @(negedge clock);
    e.hi = ehi; e.lo = elo; e.dz = edz;
    q32.push_back(e);
    op32 = op; rs32 = a; rt32 = b; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    rs32 = ~a; rt32 = b ^ 32'h5A5A_0F0F;
    got = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (i > 1) @(negedge clock);
      if (i == 1 && exp_edges > 0) chk("busy32_after_start", 32'(busy32), 32'd1);
      if (done32) begin
        got = 1'b1;
        chk("latency32", 32'(i - 1), 32'(exp_edges));
        break;
      end
      start32 = noise && (i % 5 == 0);
      if (start32) begin
        op32 = 3'b101;
        rs32 = $urandom;
      end
    end
    start32 = 1'b0;
    if (!got) chk("timeout32", 32'(got), 32'd1);
  endtask

  initial begin
    exp_t e8;
    logic got8;
    int   n;
    fork
      mon32();
      mon8();
    join_none

    repeat (2) @(negedge clock);
    chk("reset_hi", hi32, 32'h0);
    chk("reset_lo", lo32, 32'h0);
    chk("reset_busy", 32'(busy32), 32'd0);
    chk("reset_done", 32'(done32), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    run32(3'b100, 32'h11, 32'h0, 32'h11, 32'h0, 1'b0, 0, 1'b0);
    run32(3'b101, 32'h22, 32'h0, 32'h11, 32'h22, 1'b0, 0, 1'b0);
    run32(3'b010, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 0, 1'b0);
    run32(3'b000, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 33, 1'b0);
    run32(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 1'b0);
    run32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 33, 1'b0);
    run32(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    run32(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);
    run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 1'b0);
    run32(3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    run32(3'b100, 32'hDEAD, 32'h0, 32'hDEAD, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run32(3'b000, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 1'b1);
    run32(3'b011, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);

    // Reserved op: nothing happens, no done (monitor flags any stray done).
    @(negedge clock);
    op32 = 3'b110; rs32 = 32'h1234; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    chk("reserved_busy", 32'(busy32), 32'd0);
    repeat (4) @(negedge clock);
    chk("reserved_hi", hi32, 32'h0);
    chk("reserved_lo", lo32, 32'hFFFF_FFFF);

    // Reset in the middle of a divide discards it.
    @(negedge clock);
    op32 = 3'b011; rs32 = 32'd1000; rt32 = 32'd3; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) @(negedge clock);
    chk("mid_div_busy", 32'(busy32), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_hi", hi32, 32'h0);
    chk("mid_reset_lo", lo32, 32'h0);
    chk("mid_reset_busy", 32'(busy32), 32'd0);
    chk("mid_reset_done", 32'(done32), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (45) @(negedge clock);
    chk("post_reset_busy", 32'(busy32), 32'd0);

    // WIDTH=8 MULT -2 * -2.
    @(negedge clock);
    e8.hi = 32'h00; e8.lo = 32'h04; e8.dz = 1'b0;
    q8.push_back(e8);
    op8 = 3'b000; rs8 = 8'hFE; rt8 = 8'hFE; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0; rs8 = 8'h00; rt8 = 8'h00;
    got8 = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clock);
      if (done8) begin
        got8 = 1'b1;
        n = i - 1;
        break;
      end
    end
    chk("done8_seen", 32'(got8), 32'd1);
    chk("latency8", 32'(n), 32'd9);

    repeat (3) @(negedge clock);
    chk("q32_unmatched", 32'(q32.size()), 32'd0);
    chk("q8_unmatched", 32'(q8.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
